// File: rtl/pe_issuer.sv
// Issue front-end for one pe instance: feeds operand triples with update strobes,
// tracks results in flight and buffers them in a credit-protected result FIFO.
module pe_issuer #(
    parameter int WIDTH          = 8,
    parameter int PSUM_WIDTH     = 16,
    parameter int PIPELINE_STAGE = 3,
    parameter int RES_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTH-1:0]      s_data,
    input  logic [WIDTH-1:0]      s_weight,
    input  logic [PSUM_WIDTH-1:0] s_psum,
    output logic [WIDTH-1:0]      pe_data,
    output logic [WIDTH-1:0]      pe_weight,
    output logic [PSUM_WIDTH-1:0] pe_psum,
    output logic                  pe_data_update,
    output logic                  pe_weight_update,
    output logic                  pe_psum_update,
    input  logic [PSUM_WIDTH-1:0] pe_out_psum,
    input  logic                  pe_out_psum_vld,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PSUM_WIDTH-1:0] m_psum,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = AW + 1;

    // Every issued op must have a guaranteed FIFO slot, so depth has to cover the PE latency.
    if (RES_DEPTH < PIPELINE_STAGE + 1) begin : g_depth_check
        $error("pe_issuer: RES_DEPTH must be at least PIPELINE_STAGE+1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PSUM_WIDTH-1:0] mem_q [RES_DEPTH];
    logic [WIDTH-1:0]      pe_data_q, pe_weight_q;
    logic [PSUM_WIDTH-1:0] pe_psum_q;
    logic                  strobe_q;
    logic                  err_q;
    logic                  done_q;

    logic [CW:0] occupied;
    logic        has_credit;
    logic        issue;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        res_bad;
    logic        push;
    logic        drain_done;

    // Credits = RES_DEPTH - occupancy - inflight; a free credit exists while the sum is below depth.
    assign occupied   = {1'b0, count_q} + {1'b0, inflight_q};
    assign has_credit = occupied < (CW+1)'(RES_DEPTH);
    assign s_ready    = (state_q == RUN) && has_credit;
    assign issue      = s_valid && s_ready;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(RES_DEPTH));
    assign pop        = !fifo_empty && m_ready;
    assign res_bad    = pe_out_psum_vld && ((inflight_q == '0) || (fifo_full && !pop));
    assign push       = pe_out_psum_vld && !res_bad;
    assign drain_done = (state_q == DRAIN) && (inflight_q == '0) && fifo_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pe_data_q   <= '0;
            pe_weight_q <= '0;
            pe_psum_q   <= '0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            strobe_q   <= issue;
            done_q     <= drain_done;
            if (res_bad) err_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (issue) begin
                pe_data_q   <= s_data;
                pe_weight_q <= s_weight;
                pe_psum_q   <= s_psum;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which words are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pe_out_psum;
    end

    assign pe_data          = pe_data_q;
    assign pe_weight        = pe_weight_q;
    assign pe_psum          = pe_psum_q;
    assign pe_data_update   = strobe_q;
    assign pe_weight_update = strobe_q;
    assign pe_psum_update   = strobe_q;
    assign m_valid          = !fifo_empty;
    assign m_psum           = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign busy             = (state_q != IDLE);
    assign done             = done_q;
    assign err              = err_q;

endmodule
